// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, glyph table,
// receive FSM state type and the pattern-to-hex decode function.
// Glyph patterns are active-low over segments {a,b,c,d,e,f,g}.
package seg7_pkg;

  // Bit positions of each segment on the 8-bit bus
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] SEG_GLYPH_0 = 7'b0000001;
  localparam logic [6:0] SEG_GLYPH_1 = 7'b1001111;
  localparam logic [6:0] SEG_GLYPH_2 = 7'b0010010;
  localparam logic [6:0] SEG_GLYPH_3 = 7'b0000110;
  localparam logic [6:0] SEG_GLYPH_4 = 7'b1001100;
  localparam logic [6:0] SEG_GLYPH_5 = 7'b0100100;
  localparam logic [6:0] SEG_GLYPH_6 = 7'b0100000;
  localparam logic [6:0] SEG_GLYPH_7 = 7'b0001111;
  localparam logic [6:0] SEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG_GLYPH_9 = 7'b0000100;
  localparam logic [6:0] SEG_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SEG_GLYPH_B = 7'b1100000;
  localparam logic [6:0] SEG_GLYPH_C = 7'b0110001;
  localparam logic [6:0] SEG_GLYPH_D = 7'b1000010;
  localparam logic [6:0] SEG_GLYPH_E = 7'b0110000;
  localparam logic [6:0] SEG_GLYPH_F = 7'b0111000;
  // Encoder's "invalid input" glyph; deliberately not decodable
  localparam logic [6:0] SEG_GLYPH_X = 7'b1001000;

  typedef enum logic [0:0] {
    ST_WAIT    = 1'b0,
    ST_SETTLED = 1'b1
  } state_t;

  // Returns {match, hex}; match=0 for any pattern outside the 0..F glyphs
  function automatic logic [4:0] seg7_decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'b0;
    case (pat)
      SEG_GLYPH_0: r = {1'b1, 4'h0};
      SEG_GLYPH_1: r = {1'b1, 4'h1};
      SEG_GLYPH_2: r = {1'b1, 4'h2};
      SEG_GLYPH_3: r = {1'b1, 4'h3};
      SEG_GLYPH_4: r = {1'b1, 4'h4};
      SEG_GLYPH_5: r = {1'b1, 4'h5};
      SEG_GLYPH_6: r = {1'b1, 4'h6};
      SEG_GLYPH_7: r = {1'b1, 4'h7};
      SEG_GLYPH_8: r = {1'b1, 4'h8};
      SEG_GLYPH_9: r = {1'b1, 4'h9};
      SEG_GLYPH_A: r = {1'b1, 4'hA};
      SEG_GLYPH_B: r = {1'b1, 4'hB};
      SEG_GLYPH_C: r = {1'b1, 4'hC};
      SEG_GLYPH_D: r = {1'b1, 4'hD};
      SEG_GLYPH_E: r = {1'b1, 4'hE};
      SEG_GLYPH_F: r = {1'b1, 4'hF};
      default:     r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// Two-flop synchroniser plus stability counter for the segment bus.
// stable is high while the synchronised sample has been unchanged for
// STABLE_CYCLES consecutive samples; changed flags a new sample value.
module seg7_sync_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [7:0] sample,
  output logic       stable,
  output logic       changed
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] prev;
  logic [7:0] cnt;

  assign sample  = sync2;
  assign changed = (sync2 != prev);
  assign stable  = !changed && (cnt == CNT_MAX);

  // Synchronise the bus (idle = all segments off) and track sample history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
      prev  <= 8'hFF;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Count consecutive identical samples, saturating at STABLE_CYCLES-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (changed) begin
      cnt <= 8'd0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Segment-bus receiver: synchronise/debounce, decode settled patterns to
// hex and deliver them through a valid/ready holding register.
// Optional saturating error counter enabled by SEG7_RX_ERRCNT_EN.
//
// Handshake: out_valid rises when a new value is loaded and stays high,
// with hex_out/dp_out stable, until an edge where out_valid & out_ready;
// out_ready is ignored while out_valid=0. A load on the same edge as a
// handshake wins; a load over an undelivered value fires ovr_pulse.
module seg7_rx_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [3:0] hex_out,
  output logic       dp_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_pulse,
  output logic       ovr_pulse,
  output state_t     fsm_state
`ifdef SEG7_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  logic [7:0] sample;
  logic       stable;
  logic       changed;
  state_t     state;
  logic       have_last;
  logic [4:0] dec;
  logic       dec_dp;
  logic       settle_event;
  logic       is_new;
  logic       bad_glyph;
  logic       load;

  seg7_sync_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .sample (sample),
    .stable (stable),
    .changed(changed)
  );

  assign dec          = seg7_decode(sample[SEG_A:SEG_G]);
  assign dec_dp       = ~sample[SEG_DP];
  assign settle_event = (state == ST_WAIT) && stable;
  // hex_out/dp_out always mirror the last loaded value once have_last is set
  assign is_new       = !have_last || (dec[3:0] != hex_out) || (dec_dp != dp_out);
  assign bad_glyph    = settle_event && !dec[4];
  assign load         = settle_event && dec[4] && is_new;
  assign fsm_state    = state;

  // FSM plus registered delivery outputs and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_WAIT;
      hex_out   <= 4'h0;
      dp_out    <= 1'b0;
      out_valid <= 1'b0;
      have_last <= 1'b0;
      err_pulse <= 1'b0;
      ovr_pulse <= 1'b0;
    end else begin
      err_pulse <= bad_glyph;
      ovr_pulse <= load && out_valid && !out_ready;
      case (state)
        ST_WAIT:    if (stable)  state <= ST_SETTLED;
        ST_SETTLED: if (changed) state <= ST_WAIT;
        default:                 state <= ST_WAIT;
      endcase
      if (load) begin
        hex_out   <= dec[3:0];
        dp_out    <= dec_dp;
        out_valid <= 1'b1;
        have_last <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7_RX_ERRCNT_EN
  // Saturating count of illegal settled patterns, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (bad_glyph && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
